rf_writeback_ctrl: RTL and testbench
====================================

// Module: rf_writeback_ctrl
// PURPOSE
//  Write-side owner of the register file write port (rd_addr/rd_data/rd_wren).
//  - Merges results from the ALU pipe and the LSU load-return path.
//  - Buffers LSU results in a FIFO and registers the chosen write one cycle before the regfile commits it.
//  - Keeps a pending-load scoreboard and gives the issue stage a RAW/WAW hazard flag.
// PARAMETERS
//  DATA_W          32  data width of every write
//  ADDR_W          5   register address width; NUM_REGS = 2**ADDR_W
//  LSU_FIFO_DEPTH  4   LSU result buffer entries; power of 2, >= 2
// PORTS
//  i_clk           in   1       clock; all state updates on the rising edge
//  i_reset         in   1       asynchronous reset, active-low
//  i_alu_valid     in   1       ALU result present; always accepted, no backpressure
//  i_alu_rd        in   ADDR_W  ALU destination register
//  i_alu_data      in   DATA_W  ALU result
//  i_lsu_valid     in   1       load result present
//  o_lsu_ready     out  1       FIFO can accept; transfer when valid && ready
//  i_lsu_rd        in   ADDR_W  load destination register
//  i_lsu_data      in   DATA_W  load data
//  i_issue_valid   in   1       instruction issues this cycle
//  i_issue_is_load in   1       the issuing instruction is a load (marks rd pending)
//  i_issue_rd      in   ADDR_W  destination of the issuing instruction
//  i_rs1_addr      in   ADDR_W  source 1 of the candidate instruction
//  i_rs2_addr      in   ADDR_W  source 2 of the candidate instruction
//  o_hazard        out  1       candidate must stall
//  o_rd_addr       out  ADDR_W  to regfile write address
//  o_rd_data       out  DATA_W  to regfile write data
//  o_rd_wren       out  1       to regfile write enable
// BEHAVIOUR
//  Reset (async, i_reset=0):
//  - FIFO empty, scoreboard all 0.
//  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
//  - o_lsu_ready=1, o_hazard=0.
//  Arbitration in cycle N:
//  - ALU has strict priority.
//  - FIFO head pops only when i_alu_valid=0 and the FIFO is not empty.
//  - The selection is registered onto o_rd_* in cycle N+1; the regfile commits at the end of N+1.
//  - Latency is exactly 1 cycle for the ALU.
//  - The LSU path takes 1 cycle plus FIFO wait: an empty FIFO with the ALU idle gives a write in N+2 from the input handshake.
//  x0 handling:
//  - A selected write with rd=0 is consumed (FIFO pops) but drives o_rd_wren=0.
//  - Scoreboard bit 0 is never set.
//  FIFO:
//  - o_lsu_ready = !full (combinational on count; no pass-through when full).
//  - Push and pop in the same cycle are legal; count is unchanged.
//  - The pointer wraps modulo LSU_FIFO_DEPTH.
//  Scoreboard:
//  - Set bit[i_issue_rd] on i_issue_valid && i_issue_is_load && rd!=0.
//  - Clear it at the edge ending the cycle in which o_rd_wren=1, addr=rd and the write came from the LSU.
//  - If set and clear hit the same bit on the same edge, set wins.
//  Hazard:
//  - o_hazard = sb[rs1] | sb[rs2] | (i_issue_is_load & sb[i_issue_rd]).
//  - The hazard is combinational; index 0 always reads 0.
//  - The issue stage must not issue while o_hazard=1, so one pending load per register.
//  - An ALU write to a pending register is written normally and does not clear the bit.
//  Mid-operation reset: drops all FIFO contents and pending bits immediately; no write is emitted.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined:
//  - Adds ports o_fwd_rs1_en and o_fwd_rs2_en (out, 1 bit each), asserted when o_rd_wren && o_rd_addr==rsX && rsX!=0.
//  - The consumer muxes o_rd_data in for that cycle.
//  - A scoreboard bit whose clearing write is on o_rd_* this cycle is masked out of o_hazard.
//  Undefined:
//  - No fwd ports.
//  - o_hazard stays high until the cycle after the commit edge.
// STRUCTURE
//  Shared package rf_pkg:
//  - typedef wb_req_t {rd, data}
//  - localparams DATA_W, ADDR_W, NUM_REGS
//  - enum wb_src_e {WB_SRC_ALU, WB_SRC_LSU}
//  Sub-module rf_wb_fifo: parameterised wb_req_t FIFO with push/pop/full/empty/count.
//  Arbiter, output register and scoreboard live in the top module.
// TESTING
//  Reset release, idle inputs -> o_rd_wren=0, o_hazard=0, o_lsu_ready=1.
//  ALU valid rd=5 data=0xDEADBEEF in cycle N -> o_rd_wren=1, addr=5, data=0xDEADBEEF in N+1 only.
//  Issue load rd=7, then rs1=7 -> o_hazard=1.
//  - Then LSU returns rd=7 data=0x1234 with the ALU idle -> write in N+2; o_hazard=0 after the commit edge.
//  - With RF_WB_BYPASS_EN: o_hazard=0 and o_fwd_rs1_en=1 during the write cycle.
//  Hold i_alu_valid=1 and push 4 LSU results -> o_lsu_ready=0 after 4 pushes.
//  - Drop the ALU -> 4 LSU writes on consecutive cycles in push order.
//  LSU result with rd=0, data=0xFFFFFFFF -> FIFO pops, o_rd_wren stays 0, scoreboard unchanged.
//  Assert i_reset low with 3 FIFO entries and 2 pending bits -> empty FIFO, o_hazard=0, no write after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file writeback slice.
//   DATA_W / ADDR_W / NUM_REGS : write data width, register address width, register count
//   wb_src_e                   : which pipe produced a writeback
//   wb_req_t                   : one pending register write {rd, data}
package rf_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage : rf_pkg

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of wb_req_t entries buffering load results.
// Ports:
//   clk, rst_n     : clock, async active-low reset (empties the FIFO)
//   push, wdata    : enqueue request and payload (ignored while full)
//   pop, rdata     : dequeue request (ignored while empty) and head entry
//   full, empty    : occupancy flags derived from count
//   count          : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_req_t                wdata,
  input  logic                   pop,
  output wb_req_t                rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : rf_wb_fifo

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port owner: merges ALU results and buffered load returns,
// registers the chosen write one cycle ahead of the regfile commit, and tracks
// pending loads to flag RAW/WAW hazards to the issue stage.
// Ports:
//   i_clk, i_reset                 : clock, async active-low reset
//   i_alu_valid/_rd/_data          : ALU result, always accepted, highest priority
//   i_lsu_valid/_rd/_data, o_lsu_ready : load-return handshake into the FIFO
//   i_issue_valid/_is_load/_rd     : issuing instruction (loads mark rd pending)
//   i_rs1_addr, i_rs2_addr         : sources of the candidate instruction
//   o_hazard                       : candidate must stall (combinational)
//   o_rd_addr/_data/_wren          : registered regfile write port
// Build option RF_WB_BYPASS_EN: adds o_fwd_rs1_en/o_fwd_rs2_en and hides a
// pending bit from o_hazard during the cycle its clearing write is on o_rd_*.
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned LSU_FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_rd,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic [ADDR_W-1:0] i_lsu_rd,
  input  logic [DATA_W-1:0] i_lsu_data,
  input  logic              i_issue_valid,
  input  logic              i_issue_is_load,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic              o_hazard,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
`ifdef RF_WB_BYPASS_EN
  output logic              o_fwd_rs1_en,
  output logic              o_fwd_rs2_en,
`endif
  output logic              o_rd_wren
);

  localparam int unsigned CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;

  wb_req_t             lsu_req;
  wb_req_t             fifo_head;
  wb_req_t             sel_req;
  wb_src_e             sel_src;
  logic                sel_valid;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                lsu_commit;

  logic                rd_wren_q, rd_wren_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  wb_src_e             wb_src_q, wb_src_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [NUM_REGS-1:0] sb_eff;

  assign lsu_req     = '{rd: i_lsu_rd, data: i_lsu_data};
  assign o_lsu_ready = !fifo_full;

  rf_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk   (i_clk),
    .rst_n (i_reset),
    .push  (i_lsu_valid),
    .wdata (lsu_req),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Arbiter: ALU wins outright; the FIFO head drains only in ALU-idle cycles.
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = WB_SRC_ALU;
    sel_req   = '{rd: i_alu_rd, data: i_alu_data};
    fifo_pop  = 1'b0;
    if (i_alu_valid) begin
      sel_valid = 1'b1;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_src   = WB_SRC_LSU;
      sel_req   = fifo_head;
      fifo_pop  = 1'b1;
    end
  end

  // Output stage: writes to x0 are consumed but never enabled.
  always_comb begin
    rd_wren_d = sel_valid && (sel_req.rd != '0);
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    wb_src_d  = wb_src_q;
    if (sel_valid) begin
      rd_addr_d = sel_req.rd;
      rd_data_d = sel_req.data;
      wb_src_d  = sel_src;
    end
  end

  // Pending-load scoreboard; a same-edge set overrides the clear.
  always_comb begin
    lsu_commit = rd_wren_q && (wb_src_q == WB_SRC_LSU);
    sb_d       = sb_q;
    if (lsu_commit) sb_d[rd_addr_q] = 1'b0;
    if (i_issue_valid && i_issue_is_load && (i_issue_rd != '0)) sb_d[i_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Hazard view of the scoreboard; with bypass the committing load is already visible.
  always_comb begin
    sb_eff = sb_q;
`ifdef RF_WB_BYPASS_EN
    if (lsu_commit) sb_eff[rd_addr_q] = 1'b0;
`endif
    sb_eff[0] = 1'b0;
    o_hazard  = sb_eff[i_rs1_addr] | sb_eff[i_rs2_addr] |
                (i_issue_is_load & sb_eff[i_issue_rd]);
  end

`ifdef RF_WB_BYPASS_EN
  assign o_fwd_rs1_en = rd_wren_q && (rd_addr_q == i_rs1_addr) && (i_rs1_addr != '0);
  assign o_fwd_rs2_en = rd_wren_q && (rd_addr_q == i_rs2_addr) && (i_rs2_addr != '0);
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_wren_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      wb_src_q  <= WB_SRC_ALU;
      sb_q      <= '0;
    end else begin
      rd_wren_q <= rd_wren_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      wb_src_q  <= wb_src_d;
      sb_q      <= sb_d;
    end
  end

  assign o_rd_wren = rd_wren_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;

  // Occupancy can never exceed the buffer size.
  a_fifo_count_range: assert property (@(posedge i_clk) disable iff (!i_reset)
    fifo_count <= CNT_W'(LSU_FIFO_DEPTH));

endmodule : rf_writeback_ctrl

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios plus a randomized run, all
// checked against a transaction-level model (queue + pending-register array).
module tb_rf_writeback_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic        i_issue_valid;
  logic        i_issue_is_load;
  logic [4:0]  i_issue_rd;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_hazard;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
`ifdef RF_WB_BYPASS_EN
  logic        o_fwd_rs1_en;
  logic        o_fwd_rs2_en;
`endif

  always #5 i_clk = ~i_clk;

  rf_writeback_ctrl #(
    .LSU_FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_alu_valid     (i_alu_valid),
    .i_alu_rd        (i_alu_rd),
    .i_alu_data      (i_alu_data),
    .i_lsu_valid     (i_lsu_valid),
    .o_lsu_ready     (o_lsu_ready),
    .i_lsu_rd        (i_lsu_rd),
    .i_lsu_data      (i_lsu_data),
    .i_issue_valid   (i_issue_valid),
    .i_issue_is_load (i_issue_is_load),
    .i_issue_rd      (i_issue_rd),
    .i_rs1_addr      (i_rs1_addr),
    .i_rs2_addr      (i_rs2_addr),
    .o_hazard        (o_hazard),
    .o_rd_addr       (o_rd_addr),
    .o_rd_data       (o_rd_data),
`ifdef RF_WB_BYPASS_EN
    .o_fwd_rs1_en    (o_fwd_rs1_en),
    .o_fwd_rs2_en    (o_fwd_rs2_en),
`endif
    .o_rd_wren       (o_rd_wren)
  );

  // Reference model: load buffer as a queue, pending registers as a bit array,
  // and the write currently presented to the regfile.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pending;
  logic        m_wren;
  logic        m_from_lsu;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int vectors     = 0;
  int miscompares = 0;

  task automatic model_reset();
    m_q.delete();
    m_pending  = '0;
    m_wren     = 1'b0;
    m_from_lsu = 1'b0;
    m_addr     = '0;
    m_data     = '0;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_edge();
    ent_t sel;
    ent_t e;
    logic sel_v;
    logic from_lsu;
    logic accept;
    accept = i_lsu_valid && (m_q.size() < DEPTH);
    if (m_wren && m_from_lsu) m_pending[m_addr] = 1'b0;
    if (i_issue_valid && i_issue_is_load && i_issue_rd != 5'd0) m_pending[i_issue_rd] = 1'b1;
    sel_v    = 1'b0;
    from_lsu = 1'b0;
    sel.rd   = '0;
    sel.data = '0;
    if (i_alu_valid) begin
      sel_v    = 1'b1;
      sel.rd   = i_alu_rd;
      sel.data = i_alu_data;
    end else if (m_q.size() != 0) begin
      sel_v    = 1'b1;
      from_lsu = 1'b1;
      sel      = m_q.pop_front();
    end
    if (accept) begin
      e.rd   = i_lsu_rd;
      e.data = i_lsu_data;
      m_q.push_back(e);
    end
    m_wren     = sel_v && (sel.rd != 5'd0);
    m_from_lsu = from_lsu;
    m_addr     = sel.rd;
    m_data     = sel.data;
  endtask

  function automatic logic model_hazard();
    logic [31:0] eff;
    eff = m_pending;
`ifdef RF_WB_BYPASS_EN
    if (m_wren && m_from_lsu) eff[m_addr] = 1'b0;
`endif
    eff[0] = 1'b0;
    return eff[i_rs1_addr] | eff[i_rs2_addr] | (i_issue_is_load & eff[i_issue_rd]);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    if (!i_reset) model_reset();
    else          model_edge();
    #1;
  endtask

  task automatic idle();
    i_alu_valid     = 1'b0;
    i_alu_rd        = '0;
    i_alu_data      = '0;
    i_lsu_valid     = 1'b0;
    i_lsu_rd        = '0;
    i_lsu_data      = '0;
    i_issue_valid   = 1'b0;
    i_issue_is_load = 1'b0;
    i_issue_rd      = '0;
    i_rs1_addr      = '0;
    i_rs2_addr      = '0;
  endtask

  task automatic test_reset();
    idle();
    @(negedge i_clk);
    vectors++; if (o_rd_wren !== 1'b0) begin miscompares++; $display("FAIL reset_wren got=%b exp=0", o_rd_wren); end
    vectors++; if (o_hazard !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got=%b exp=0", o_hazard); end
    vectors++; if (o_lsu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", o_lsu_ready); end
    vectors++; if (o_rd_addr !== 5'd0 || o_rd_data !== 32'd0) begin miscompares++; $display("FAIL reset_addr_data got=%0d/%h exp=0/0", o_rd_addr, o_rd_data); end
    tick();
  endtask

  task automatic test_alu();
    idle();
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
    tick();
    idle();
    @(negedge i_clk);
    vectors++; if (o_rd_wren !== 1'b1) begin miscompares++; $display("FAIL alu_wren got=%b exp=1", o_rd_wren); end
    vectors++; if (o_rd_addr !== 5'd5) begin miscompares++; $display("FAIL alu_addr got=%0d exp=5", o_rd_addr); end
    vectors++; if (o_rd_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL alu_data got=%h exp=deadbeef", o_rd_data); end
    tick();
    @(negedge i_clk);
    vectors++; if (o_rd_wren !== 1'b0) begin miscompares++; $display("FAIL alu_one_cycle got=%b exp=0", o_rd_wren); end
    tick();
  endtask

  task automatic test_load_hazard();
    idle();
    i_issue_valid = 1'b1; i_issue_is_load = 1'b1; i_issue_rd = 5'd7;
    tick();
    idle();
    i_rs1_addr = 5'd7;
    @(negedge i_clk);
    vectors++; if (o_hazard !== 1'b1) begin miscompares++; $display("FAIL raw_pending got=%b exp=1", o_hazard); end
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd7; i_lsu_data = 32'h1234;
    tick();
    i_lsu_valid = 1'b0;
    @(negedge i_clk);
    vectors++; if (o_rd_wren !== 1'b0) begin miscompares++; $display("FAIL lsu_not_early got=%b exp=0", o_rd_wren); end
    vectors++; if (o_hazard !== 1'b1) begin miscompares++; $display("FAIL hazard_held got=%b exp=1", o_hazard); end
    tick();
    @(negedge i_clk);
    vectors++; if (o_rd_wren !== 1'b1 || o_rd_addr !== 5'd7 || o_rd_data !== 32'h1234) begin
      miscompares++; $display("FAIL lsu_write got=%b/%0d/%h exp=1/7/00001234", o_rd_wren, o_rd_addr, o_rd_data);
    end
`ifdef RF_WB_BYPASS_EN
    vectors++; if (o_hazard !== 1'b0) begin miscompares++; $display("FAIL bypass_hazard got=%b exp=0", o_hazard); end
    vectors++; if (o_fwd_rs1_en !== 1'b1) begin miscompares++; $display("FAIL fwd_rs1 got=%b exp=1", o_fwd_rs1_en); end
    vectors++; if (o_fwd_rs2_en !== 1'b0) begin miscompares++; $display("FAIL fwd_rs2_x0 got=%b exp=0", o_fwd_rs2_en); end
`else
    vectors++; if (o_hazard !== 1'b1) begin miscompares++; $display("FAIL commit_cycle_hazard got=%b exp=1", o_hazard); end
`endif
    tick();
    @(negedge i_clk);
    vectors++; if (o_hazard !== 1'b0) begin miscompares++; $display("FAIL hazard_cleared got=%b exp=0", o_hazard); end
    vectors++; if (o_rd_wren !== 1'b0) begin miscompares++; $display("FAIL lsu_one_cycle got=%b exp=0", o_rd_wren); end
    idle();
    tick();
  endtask

  task automatic test_fifo_full();
    logic [31:0] pushed [4];
    idle();
    i_alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_alu_rd    = 5'(i + 1);
      i_alu_data  = $urandom;
      i_lsu_valid = 1'b1;
      i_lsu_rd    = 5'(10 + i);
      i_lsu_data  = $urandom;
      pushed[i]   = i_lsu_data;
      @(negedge i_clk);
      vectors++; if (o_lsu_ready !== 1'b1) begin miscompares++; $display("FAIL ready_before_full i=%0d got=%b exp=1", i, o_lsu_ready); end
      if (i > 0) begin
        vectors++; if (o_rd_wren !== 1'b1 || o_rd_addr !== 5'(i)) begin miscompares++; $display("FAIL alu_while_fill i=%0d got=%b/%0d exp=1/%0d", i, o_rd_wren, o_rd_addr, i); end
      end
      tick();
    end
    i_alu_rd = 5'd30; i_lsu_rd = 5'd31; i_lsu_data = 32'hBAD0BAD0;
    @(negedge i_clk);
    vectors++; if (o_lsu_ready !== 1'b0) begin miscompares++; $display("FAIL ready_full got=%b exp=0", o_lsu_ready); end
    tick();
    idle();
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      vectors++; if (o_rd_wren !== 1'b1 || o_rd_addr !== 5'(10 + i) || o_rd_data !== pushed[i]) begin
        miscompares++; $display("FAIL drain_order i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, o_rd_wren, o_rd_addr, o_rd_data, 10 + i, pushed[i]);
      end
      tick();
    end
    @(negedge i_clk);
    vectors++; if (o_rd_wren !== 1'b0) begin miscompares++; $display("FAIL full_push_dropped got=%b exp=0", o_rd_wren); end
    tick();
  endtask

  task automatic test_x0();
    idle();
    i_issue_valid = 1'b1; i_issue_is_load = 1'b1; i_issue_rd = 5'd9;
    tick();
    idle();
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd0; i_lsu_data = 32'hFFFFFFFF;
    tick();
    idle();
    tick();
    @(negedge i_clk);
    vectors++; if (o_rd_wren !== 1'b0) begin miscompares++; $display("FAIL x0_no_write got=%b exp=0", o_rd_wren); end
    vectors++; if (o_hazard !== 1'b0) begin miscompares++; $display("FAIL x0_index0_hazard got=%b exp=0", o_hazard); end
    i_rs2_addr = 5'd9;
    #1;
    vectors++; if (o_hazard !== 1'b1) begin miscompares++; $display("FAIL x0_sb_unchanged got=%b exp=1", o_hazard); end
    i_rs2_addr  = 5'd0;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd9; i_lsu_data = 32'h0000ABCD;
    tick();
    idle();
    tick();
    @(negedge i_clk);
    vectors++; if (o_rd_wren !== 1'b1 || o_rd_addr !== 5'd9 || o_rd_data !== 32'h0000ABCD) begin
      miscompares++; $display("FAIL x0_popped got=%b/%0d/%h exp=1/9/0000abcd", o_rd_wren, o_rd_addr, o_rd_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 3; i++) begin
      i_alu_valid     = 1'b1;
      i_alu_rd        = 5'(1 + i);
      i_alu_data      = $urandom;
      i_lsu_valid     = 1'b1;
      i_lsu_rd        = 5'(20 + i);
      i_lsu_data      = $urandom;
      i_issue_valid   = (i < 2);
      i_issue_is_load = (i < 2);
      i_issue_rd      = 5'(3 + i);
      tick();
    end
    idle();
    i_alu_valid = 1'b1; i_alu_rd = 5'd6; i_alu_data = 32'h600D600D;
    i_rs1_addr = 5'd3; i_rs2_addr = 5'd4;
    @(negedge i_clk);
    vectors++; if (o_hazard !== 1'b1) begin miscompares++; $display("FAIL pre_reset_hazard got=%b exp=1", o_hazard); end
    #2;
    i_reset = 1'b0;
    #1;
    vectors++; if (o_rd_wren !== 1'b0 || o_rd_addr !== 5'd0 || o_rd_data !== 32'd0) begin
      miscompares++; $display("FAIL midreset_out got=%b/%0d/%h exp=0/0/0", o_rd_wren, o_rd_addr, o_rd_data);
    end
    vectors++; if (o_hazard !== 1'b0) begin miscompares++; $display("FAIL midreset_hazard got=%b exp=0", o_hazard); end
    vectors++; if (o_lsu_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready got=%b exp=1", o_lsu_ready); end
    i_alu_valid = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      vectors++; if (o_rd_wren !== 1'b0) begin miscompares++; $display("FAIL post_reset_write i=%0d got=%b exp=0", i, o_rd_wren); end
      vectors++; if (o_hazard !== 1'b0) begin miscompares++; $display("FAIL post_reset_hazard i=%0d got=%b exp=0", i, o_hazard); end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    logic exp_fwd1;
    logic exp_fwd2;
    for (int c = 0; c < 400; c++) begin
      i_alu_valid     = ($urandom_range(3) == 0);
      i_alu_rd        = 5'($urandom_range(7));
      i_alu_data      = $urandom;
      i_lsu_valid     = $urandom_range(1);
      i_lsu_rd        = 5'($urandom_range(7));
      i_lsu_data      = $urandom;
      i_issue_valid   = $urandom_range(1);
      i_issue_is_load = $urandom_range(1);
      i_issue_rd      = 5'($urandom_range(7));
      i_rs1_addr      = 5'($urandom_range(7));
      i_rs2_addr      = 5'($urandom_range(7));
      @(negedge i_clk);
      vectors++; if (o_rd_wren !== m_wren) begin miscompares++; $display("FAIL rnd_wren c=%0d got=%b exp=%b", c, o_rd_wren, m_wren); end
      if (m_wren) begin
        vectors++; if (o_rd_addr !== m_addr || o_rd_data !== m_data) begin
          miscompares++; $display("FAIL rnd_write c=%0d got=%0d/%h exp=%0d/%h", c, o_rd_addr, o_rd_data, m_addr, m_data);
        end
      end
      vectors++; if (o_lsu_ready !== (m_q.size() < DEPTH)) begin miscompares++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, o_lsu_ready, m_q.size() < DEPTH); end
      vectors++; if (o_hazard !== model_hazard()) begin miscompares++; $display("FAIL rnd_hazard c=%0d got=%b exp=%b", c, o_hazard, model_hazard()); end
      exp_fwd1 = m_wren && (m_addr == i_rs1_addr) && (i_rs1_addr != 5'd0);
      exp_fwd2 = m_wren && (m_addr == i_rs2_addr) && (i_rs2_addr != 5'd0);
`ifdef RF_WB_BYPASS_EN
      vectors++; if (o_fwd_rs1_en !== exp_fwd1 || o_fwd_rs2_en !== exp_fwd2) begin
        miscompares++; $display("FAIL rnd_fwd c=%0d got=%b%b exp=%b%b", c, o_fwd_rs1_en, o_fwd_rs2_en, exp_fwd1, exp_fwd2);
      end
`endif
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    i_reset = 1'b0;
    model_reset();
    repeat (3) tick();
    i_reset = 1'b1;
    test_reset();
    test_alu();
    test_load_hazard();
    test_fifo_full();
    test_x0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rf_writeback_ctrl
